// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the binary-to-BCD converter
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/dabble_cell.sv
// rtl/dabble_cell.sv - one BCD digit add-3-if-at-least-5 adjust stage
module dabble_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    always_comb begin
        q = d;
        if (d >= BCD_ADJ_THRESH) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - sequential double-dabble binary to packed BCD converter
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    state_t           state;
    logic [BIN_W-1:0] shreg;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    adj;
    logic [CW-1:0]    cnt;
    logic             ovf_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        dabble_cell u_cell (
            .d (scratch[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= bin;
                        scratch  <= '0;
                        cnt      <= CW'(BIN_W);
                        ovf_next <= (32'(bin) > MAX_VAL);
                        ready    <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A carry out of the top digit can only happen for out-of-range input
                    {scratch, shreg} <= {adj[SW-2:0], shreg, 1'b0};
                    ovf_next         <= ovf_next | adj[SW-1];
                    cnt              <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= ovf_next ? {DIGITS{4'h9}} : scratch;
                    ovf   <= ovf_next;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb/tb_bin_to_bcd.sv - self-checking bench for bin_to_bcd against a decimal reference model
module tb_bin_to_bcd;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int NLIT   = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [BIN_W-1:0]  bin = '0;
    logic              ready;
    logic              done;
    logic [15:0]       bcd;
    logic              ovf;

    bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Hand-computed results, in the order the done pulses must occur
    logic [15:0] lit_bcd [0:NLIT-1] = '{16'h0000, 16'h1234, 16'h9999, 16'h9999, 16'h9999,
                                        16'h0042, 16'h0777, 16'h4321, 16'h0000};
    logic        lit_ovf [0:NLIT-1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          x;
        if (v > 9999) return 16'h9999;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: a conversion finishes BIN_W+1 edges after its accept edge
    int          m_cnt  = 0;
    int          m_val  = 0;
    logic [15:0] m_bcd  = '0;
    logic        m_ovf  = 1'b0;
    logic        m_done = 1'b0;
    logic        armed  = 1'b0;

    always @(posedge clk) begin
        armed = 1'b1;
        if (reset) begin
            m_cnt  = 0;
            m_bcd  = '0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_bcd  = ref_bcd(m_val);
                    m_ovf  = (m_val > 9999);
                end
            end else if (start) begin
                m_val = int'(bin);
                m_cnt = BIN_W + 1;
            end
        end
    end

    int ndone = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("ready", 32'(ready), 32'(m_cnt == 0));
            chk("done",  32'(done),  32'(m_done));
            chk("bcd",   32'(bcd),   32'(m_bcd));
            chk("ovf",   32'(ovf),   32'(m_ovf));
            if (done === 1'b1) begin
                if (ndone < NLIT) begin
                    chk("lit_bcd", 32'(bcd), 32'(lit_bcd[ndone]));
                    chk("lit_ovf", 32'(ovf), 32'(lit_ovf[ndone]));
                end
                ndone++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic convert(input int v);
        bin   = BIN_W'(v);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(20);
    endtask

    initial begin
        // reset held with start high: reset must win
        bin   = BIN_W'(5);
        start = 1'b1;
        cycles(3);
        start = 1'b0;
        reset = 1'b0;
        cycles(2);

        convert(0);
        convert(1234);
        convert(9999);
        convert(10000);
        convert(16383);
        convert(42);

        // start during SHIFT is ignored
        bin   = BIN_W'(777);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(5);
        bin   = BIN_W'(555);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(25);

        // reset mid-conversion aborts without a done pulse
        bin   = BIN_W'(4321);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(6);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(3);
        convert(4321);

        // back-to-back conversions with start held high
        start = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            bin = BIN_W'(j);
            cycles(16);
        end
        start = 1'b0;
        cycles(20);

        n_vec++;
        if (ndone != NLIT + 20) begin
            n_err++;
            $display("FAIL done_count: got %0d, expected %0d", ndone, NLIT + 20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
